warp_ctx_queue: RTL and testbench

- Parametrised FIFO of warp register-set contexts, sitting between the warp scheduler (push side) and the dispatch/issue stage (pop side).
- Strobe-based push/pop with registered read data and exact occupancy count.
- Adds almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags with explicit clear.

---
 rtl/gpu_pkg.sv | 8 +
 rtl/warp_ctx_queue_if.sv | 37 +++
 rtl/warp_ctx_queue_sdp_ram.sv | 39 +++
 rtl/warp_ctx_queue.sv | 105 ++++++++++
 tb/tb_warp_ctx_queue.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU-wide definitions: register-set entry width and its carrier type.
package gpu_pkg;

   localparam int REGSET_W = 256;

   typedef logic [REGSET_W-1:0] regset_t;

endpackage

// File: rtl/warp_ctx_queue_if.sv
// Scheduler-to-dispatch context queue bus; master drives push/pop, slave is the queue.
interface warp_ctx_queue_if
   import gpu_pkg::*;
#(
   parameter int DATA_W = REGSET_W,
   parameter int DEPTH  = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              flush;
   logic              push;
   logic [DATA_W-1:0] push_data;
   logic              pop;
   logic [DATA_W-1:0] pop_data;
   logic              pop_valid;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic              err_overflow;
   logic              err_underflow;
   logic              err_clear;

   modport master (
      output flush, push, push_data, pop, err_clear,
      input  pop_data, pop_valid, count, full, empty, almost_full, almost_empty,
             err_overflow, err_underflow
   );

   modport slave (
      input  flush, push, push_data, pop, err_clear,
      output pop_data, pop_valid, count, full, empty, almost_full, almost_empty,
             err_overflow, err_underflow
   );

endinterface

// File: rtl/warp_ctx_queue_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module sdp_ram
   import gpu_pkg::*;
#(
   parameter int DATA_W = REGSET_W,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // NOTE: the array has no reset so it maps onto RAM cells; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // A same-address write and read return the old word (read-before-write).
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[raddr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/warp_ctx_queue.sv
// FIFO of warp register-set contexts between the warp scheduler and dispatch, with
// thresholds, synchronous flush and sticky overflow/underflow flags.
module warp_ctx_queue
   import gpu_pkg::*;
#(
   parameter int DATA_W    = REGSET_W,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input logic            clk,
   input logic            rst_n,
   warp_ctx_queue_if.slave q
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_valid_q, pop_valid_d;
   logic          err_ovf_q, err_ovf_d;
   logic          err_udf_q, err_udf_d;
   logic          push_ok, pop_ok;
   logic          full, empty;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      pop_ok      = q.pop & ~empty & ~q.flush;
      push_ok     = q.push & (~full | pop_ok) & ~q.flush;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      pop_valid_d = pop_ok;

      if (q.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      // A new error event in the same cycle as err_clear wins.
      err_ovf_d = (err_ovf_q & ~q.err_clear) | (q.push & ~q.flush & ~push_ok);
      err_udf_d = (err_udf_q & ~q.err_clear) | (q.pop & ~q.flush & empty);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pop_valid_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_udf_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pop_valid_q <= pop_valid_d;
         err_ovf_q   <= err_ovf_d;
         err_udf_q   <= err_udf_d;
      end
   end

   sdp_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (push_ok),
      .waddr (wr_ptr_q),
      .wdata (q.push_data),
      .re    (pop_ok),
      .raddr (rd_ptr_q),
      .rdata (q.pop_data)
   );

   assign q.pop_valid     = pop_valid_q;
   assign q.count         = count_q;
   assign q.full          = full;
   assign q.empty         = empty;
   assign q.almost_full   = (count_q >= AFULL_C);
   assign q.almost_empty  = (count_q <= AEMPTY_C);
   assign q.err_overflow  = err_ovf_q;
   assign q.err_underflow = err_udf_q;

endmodule

// File: tb/tb_warp_ctx_queue.sv
// Table-driven bench for warp_ctx_queue (DEPTH=4, DATA_W=8, AFULL_TH=3, AEMPTY_TH=1)
// with a pop-data scoreboard and a hand-written asynchronous-reset sequence.
module tb_warp_ctx_queue;

   localparam int DW = 8;
   localparam int DP = 4;

   typedef struct {
      logic          push;
      logic [DW-1:0] pdata;
      logic          pop;
      logic          ok;
      logic [DW-1:0] pexp;
      logic          flush;
      logic          eclr;
      int            cnt;
      logic          ovf;
      logic          udf;
   } vec_t;

   logic clk;
   logic rst_n;

   vec_t          tbl[$];
   logic [DW-1:0] sb[$];
   logic [DW-1:0] last_data;
   int            n_tests;
   int            n_fail;

   warp_ctx_queue_if #(.DATA_W(DW), .DEPTH(DP)) qif ();

   warp_ctx_queue #(
      .DATA_W    (DW),
      .DEPTH     (DP),
      .AFULL_TH  (3),
      .AEMPTY_TH (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (qif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void row(input logic pu, input logic [DW-1:0] pd, input logic po,
                               input logic ok, input logic [DW-1:0] pe, input logic fl,
                               input logic ec, input int cnt, input logic ovf, input logic udf);
      vec_t v;
      v.push = pu; v.pdata = pd; v.pop = po; v.ok = ok; v.pexp = pe;
      v.flush = fl; v.eclr = ec; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
      tbl.push_back(v);
   endfunction

   task automatic drive_idle();
      qif.push = 1'b0; qif.push_data = '0; qif.pop = 1'b0;
      qif.flush = 1'b0; qif.err_clear = 1'b0;
   endtask

   // Called at a falling edge: drive the row, let one rising edge pass, compare at the next falling edge.
   task automatic run_row(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("row%0d", idx);
      qif.push = v.push; qif.push_data = v.pdata; qif.pop = v.pop;
      qif.flush = v.flush; qif.err_clear = v.eclr;
      if (v.ok) sb.push_back(v.pexp);
      @(posedge clk);
      @(negedge clk);
      check({tag, " count"},        32'(qif.count),        32'(v.cnt));
      check({tag, " full"},         32'(qif.full),         32'(v.cnt == DP));
      check({tag, " empty"},        32'(qif.empty),        32'(v.cnt == 0));
      check({tag, " almost_full"},  32'(qif.almost_full),  32'(v.cnt >= 3));
      check({tag, " almost_empty"}, 32'(qif.almost_empty), 32'(v.cnt <= 1));
      check({tag, " err_overflow"}, 32'(qif.err_overflow), 32'(v.ovf));
      check({tag, " err_underflow"},32'(qif.err_underflow),32'(v.udf));
      check({tag, " pop_valid"},    32'(qif.pop_valid),    32'(v.ok));
      if (qif.pop_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s pop_data: got %0h, expected no pop", tag, qif.pop_data);
         end else begin
            last_data = sb.pop_front();
            check({tag, " pop_data"}, 32'(qif.pop_data), 32'(last_data));
         end
      end else begin
         if (v.ok && sb.size() != 0) void'(sb.pop_front());
         check({tag, " pop_data hold"}, 32'(qif.pop_data), 32'(last_data));
      end
   endtask

   task automatic run_table();
      for (int i = 0; i < tbl.size(); i++) run_row(i, tbl[i]);
      tbl.delete();
   endtask

   initial begin
      n_tests = 0; n_fail = 0; last_data = '0;
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset count",     32'(qif.count),         32'd0);
      check("reset empty",     32'(qif.empty),         32'd1);
      check("reset pop_valid", 32'(qif.pop_valid),     32'd0);
      check("reset pop_data",  32'(qif.pop_data),      32'd0);
      check("reset err_ovf",   32'(qif.err_overflow),  32'd0);
      check("reset err_udf",   32'(qif.err_underflow), 32'd0);
      rst_n = 1'b1;

      // fill to full, drop a 5th push
      row(1, 8'hA1, 0, 0, 0, 0, 0, 1, 0, 0);
      row(1, 8'hA2, 0, 0, 0, 0, 0, 2, 0, 0);
      row(1, 8'hA3, 0, 0, 0, 0, 0, 3, 0, 0);
      row(1, 8'hA4, 0, 0, 0, 0, 0, 4, 0, 0);
      row(1, 8'hA5, 0, 0, 0, 0, 0, 4, 1, 0);
      // drain, then one pop too many
      row(0, 0, 1, 1, 8'hA1, 0, 0, 3, 1, 0);
      row(0, 0, 1, 1, 8'hA2, 0, 0, 2, 1, 0);
      row(0, 0, 1, 1, 8'hA3, 0, 0, 1, 1, 0);
      row(0, 0, 1, 1, 8'hA4, 0, 0, 0, 1, 0);
      row(0, 0, 1, 0, 0,     0, 0, 0, 1, 1);
      row(0, 0, 0, 0, 0,     0, 1, 0, 0, 0);
      // pointer wrap-around
      for (int i = 0; i < 10; i++) begin
         row(1, 8'(8'h10 + i), 0, 0, 0, 0, 0, 1, 0, 0);
         row(0, 0, 1, 1, 8'(8'h10 + i), 0, 0, 0, 0, 0);
      end
      // simultaneous push and pop while full
      row(1, 8'hC1, 0, 0, 0, 0, 0, 1, 0, 0);
      row(1, 8'hC2, 0, 0, 0, 0, 0, 2, 0, 0);
      row(1, 8'hC3, 0, 0, 0, 0, 0, 3, 0, 0);
      row(1, 8'hC4, 0, 0, 0, 0, 0, 4, 0, 0);
      row(1, 8'hB0, 1, 1, 8'hC1, 0, 0, 4, 0, 0);
      row(0, 0, 1, 1, 8'hC2, 0, 0, 3, 0, 0);
      row(0, 0, 1, 1, 8'hC3, 0, 0, 2, 0, 0);
      row(0, 0, 1, 1, 8'hC4, 0, 0, 1, 0, 0);
      row(0, 0, 1, 1, 8'hB0, 0, 0, 0, 0, 0);
      // flush overrides a same-cycle push
      row(1, 8'hD1, 0, 0, 0, 0, 0, 1, 0, 0);
      row(1, 8'hD2, 0, 0, 0, 0, 0, 2, 0, 0);
      row(1, 8'hD3, 0, 0, 0, 0, 0, 3, 0, 0);
      row(1, 8'hD4, 0, 0, 0, 1, 0, 0, 0, 0);
      row(1, 8'hE1, 0, 0, 0, 0, 0, 1, 0, 0);
      row(0, 0, 1, 1, 8'hE1, 0, 0, 0, 0, 0);
      // sticky flags, clear, set-wins, flush leaves flags alone
      row(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      row(1, 8'hF1, 0, 0, 0, 0, 0, 1, 0, 1);
      row(1, 8'hF2, 0, 0, 0, 0, 0, 2, 0, 1);
      row(1, 8'hF3, 0, 0, 0, 0, 0, 3, 0, 1);
      row(1, 8'hF4, 0, 0, 0, 0, 0, 4, 0, 1);
      row(1, 8'hF5, 0, 0, 0, 0, 0, 4, 1, 1);
      row(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
      row(1, 8'hF6, 0, 0, 0, 0, 1, 4, 1, 0);
      row(0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
      row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      row(0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
      row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      // push and pop together on empty: push lands, pop is refused
      row(1, 8'h61, 1, 0, 0, 0, 0, 1, 0, 1);
      row(0, 0, 1, 1, 8'h61, 0, 0, 0, 0, 1);
      row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      // set up count=2 with a sticky flag ahead of the async reset
      row(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      row(1, 8'h71, 0, 0, 0, 0, 0, 1, 0, 1);
      row(1, 8'h72, 0, 0, 0, 0, 0, 2, 0, 1);
      run_table();

      // asynchronous reset mid-cycle with a pop pending
      qif.pop = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("async count",     32'(qif.count),         32'd0);
      check("async empty",     32'(qif.empty),         32'd1);
      check("async pop_valid", 32'(qif.pop_valid),     32'd0);
      check("async pop_data",  32'(qif.pop_data),      32'd0);
      check("async err_ovf",   32'(qif.err_overflow),  32'd0);
      check("async err_udf",   32'(qif.err_underflow), 32'd0);
      sb.delete();
      last_data = '0;
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      row(1, 8'h81, 0, 0, 0, 0, 0, 1, 0, 0);
      row(1, 8'h82, 0, 0, 0, 0, 0, 2, 0, 0);
      row(0, 0, 1, 1, 8'h81, 0, 0, 1, 0, 0);
      row(0, 0, 1, 1, 8'h82, 0, 0, 0, 0, 0);
      row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_table();

      if (sb.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
